// File: rtl/mmio_pkg.sv
// rtl/mmio_pkg.sv - shared addresses, widths and debounce state type for the MMIO bridge
package mmio_pkg;
    localparam logic [31:0] DIG_ADDR_DEF  = 32'hFFFF_F000;
    localparam logic [31:0] LED_ADDR_DEF  = 32'hFFFF_F060;
    localparam logic [31:0] SW_ADDR_DEF   = 32'hFFFF_F070;
    localparam logic [31:0] BTN_ADDR_DEF  = 32'hFFFF_F078;
    localparam logic [31:0] TIMER_OFS     = 32'h0000_0010;
    localparam int unsigned DEB_END_DEF   = 2000000 - 1;
    localparam int          LED_W         = 24;
    localparam int          BTN_W         = 5;

    typedef enum logic {
        DEB_STABLE   = 1'b0,
        DEB_COUNTING = 1'b1
    } deb_state_e;
endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - single-bit debouncer: output follows input only after DEB_END+1 stable cycles
module btn_debounce
    import mmio_pkg::*;
#(
    parameter int unsigned DEB_END = DEB_END_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sync_i,
    output logic db_o
);
    deb_state_e  state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic        db_q, db_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= DEB_STABLE;
            cnt_q   <= '0;
            db_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            db_q    <= db_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        db_d    = db_q;
        case (state_q)
            DEB_STABLE: begin
                if (sync_i != db_q) begin
                    state_d = DEB_COUNTING;
                    cnt_d   = '0;
                end
            end
            DEB_COUNTING: begin
                // A bounce back to the current output abandons the count silently
                if (sync_i == db_q) begin
                    state_d = DEB_STABLE;
                end else if (cnt_q == DEB_END) begin
                    db_d    = sync_i;
                    state_d = DEB_STABLE;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: state_d = DEB_STABLE;
        endcase
    end

    assign db_o = db_q;
endmodule

// File: rtl/mmio_bridge.sv
// rtl/mmio_bridge.sv - CPU-to-peripheral MMIO bridge (display, LEDs, switches, buttons)
// Optional cycle timer at DIG_ADDR+0x10 when MMIO_BRIDGE_TIMER_EN is defined.
module mmio_bridge
    import mmio_pkg::*;
#(
    parameter logic [31:0] DIG_ADDR = DIG_ADDR_DEF,
    parameter logic [31:0] LED_ADDR = LED_ADDR_DEF,
    parameter logic [31:0] SW_ADDR  = SW_ADDR_DEF,
    parameter logic [31:0] BTN_ADDR = BTN_ADDR_DEF,
    parameter int unsigned DEB_END  = DEB_END_DEF
) (
    input  logic               clk_to_bridge,
    input  logic               rst_to_bridge,
    input  logic [31:0]        addr_from_cpu,
    input  logic               we_from_cpu,
    input  logic               re_from_cpu,
    input  logic [31:0]        wdata_from_cpu,
    output logic [31:0]        rdata_to_cpu,
    output logic               hit_to_cpu,
    output logic [31:0]        addr_to_dig,
    output logic               we_to_dig,
    output logic [31:0]        wdata_to_dig,
    output logic [LED_W-1:0]   led_out,
    input  logic [LED_W-1:0]   sw_in,
    input  logic [BTN_W-1:0]   btn_in
);
    logic               hit_dig, hit_led, hit_sw, hit_btn, hit_tmr;
    logic               dig_we_q;
    logic [31:0]        dig_wdata_q, dig_addr_q;
    logic [LED_W-1:0]   led_q;
    logic [LED_W-1:0]   sw_s1_q, sw_s2_q;
    logic [BTN_W-1:0]   btn_s1_q, btn_s2_q, btn_db;
    logic [31:0]        rdata_q, rdata_d;

    assign hit_dig    = (addr_from_cpu == DIG_ADDR);
    assign hit_led    = (addr_from_cpu == LED_ADDR);
    assign hit_sw     = (addr_from_cpu == SW_ADDR);
    assign hit_btn    = (addr_from_cpu == BTN_ADDR);
    assign hit_to_cpu = hit_dig | hit_led | hit_sw | hit_btn | hit_tmr;

`ifdef MMIO_BRIDGE_TIMER_EN
    logic [31:0] timer_q;
    assign hit_tmr = (addr_from_cpu == DIG_ADDR + TIMER_OFS);

    always_ff @(posedge clk_to_bridge or posedge rst_to_bridge) begin
        if (rst_to_bridge)                  timer_q <= '0;
        else if (we_from_cpu && hit_tmr)    timer_q <= '0;
        else                                timer_q <= timer_q + 32'd1;
    end
`else
    assign hit_tmr = 1'b0;
`endif

    // Reads sample pre-edge state, so a same-cycle store is not yet visible
    always_comb begin
        rdata_d = '0;
        if (re_from_cpu) begin
            if (hit_dig)      rdata_d = dig_wdata_q;
            else if (hit_led) rdata_d = {{(32-LED_W){1'b0}}, led_q};
            else if (hit_sw)  rdata_d = {{(32-LED_W){1'b0}}, sw_s2_q};
            else if (hit_btn) rdata_d = {{(32-BTN_W){1'b0}}, btn_db};
`ifdef MMIO_BRIDGE_TIMER_EN
            else if (hit_tmr) rdata_d = timer_q;
`endif
        end
    end

    always_ff @(posedge clk_to_bridge or posedge rst_to_bridge) begin
        if (rst_to_bridge) begin
            dig_we_q    <= 1'b0;
            dig_wdata_q <= '0;
            dig_addr_q  <= '0;
            led_q       <= '0;
            rdata_q     <= '0;
            sw_s1_q     <= '0;
            sw_s2_q     <= '0;
            btn_s1_q    <= '0;
            btn_s2_q    <= '0;
        end else begin
            dig_we_q <= we_from_cpu && hit_dig;
            if (we_from_cpu && hit_dig) begin
                dig_wdata_q <= wdata_from_cpu;
                dig_addr_q  <= addr_from_cpu;
            end
            if (we_from_cpu && hit_led) led_q <= wdata_from_cpu[LED_W-1:0];
            rdata_q  <= rdata_d;
            sw_s1_q  <= sw_in;
            sw_s2_q  <= sw_s1_q;
            btn_s1_q <= btn_in;
            btn_s2_q <= btn_s1_q;
        end
    end

    for (genvar i = 0; i < BTN_W; i++) begin : g_deb
        btn_debounce #(.DEB_END(DEB_END)) u_deb (
            .clk_i  (clk_to_bridge),
            .rst_i  (rst_to_bridge),
            .sync_i (btn_s2_q[i]),
            .db_o   (btn_db[i])
        );
    end

    assign we_to_dig    = dig_we_q;
    assign wdata_to_dig = dig_wdata_q;
    assign addr_to_dig  = dig_addr_q;
    assign led_out      = led_q;
    assign rdata_to_cpu = rdata_q;
endmodule

// File: tb/tb_mmio_bridge.sv
// tb/tb_mmio_bridge.sv - scoreboard bench for mmio_bridge (honours MMIO_BRIDGE_TIMER_EN)
module tb_mmio_bridge;
    localparam logic [31:0] DIG = 32'hFFFF_F000;
    localparam logic [31:0] LED = 32'hFFFF_F060;
    localparam logic [31:0] SW  = 32'hFFFF_F070;
    localparam logic [31:0] BTN = 32'hFFFF_F078;
    localparam logic [31:0] TMR = 32'hFFFF_F010;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr = '0, wdata = '0;
    logic        we = 1'b0, re = 1'b0;
    logic [31:0] rdata, addr_to_dig, wdata_to_dig;
    logic        hit, we_to_dig;
    logic [23:0] led_out, sw_in = '0;
    logic [4:0]  btn_in = '0;

    always #5 clk = ~clk;

    mmio_bridge #(.DEB_END(15)) dut (
        .clk_to_bridge  (clk),
        .rst_to_bridge  (rst),
        .addr_from_cpu  (addr),
        .we_from_cpu    (we),
        .re_from_cpu    (re),
        .wdata_from_cpu (wdata),
        .rdata_to_cpu   (rdata),
        .hit_to_cpu     (hit),
        .addr_to_dig    (addr_to_dig),
        .we_to_dig      (we_to_dig),
        .wdata_to_dig   (wdata_to_dig),
        .led_out        (led_out),
        .sw_in          (sw_in),
        .btn_in         (btn_in)
    );

    typedef struct {
        string       tag;
        logic [31:0] exp;
        logic [31:0] tol;
    } rd_exp_t;

    rd_exp_t     rd_q[$];
    logic [31:0] dig_q[$];
    int          tests = 0;
    int          fails = 0;
    int          dig_pulses = 0;
    logic        mon_re;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard: read results and display pulses are compared just after the edge that produces them
    always @(posedge clk) begin
        rd_exp_t     e;
        logic [31:0] diff;
        mon_re = re && !rst;
        #1;
        if (mon_re) begin
            if (rd_q.size() == 0) begin
                check("rd_unexpected", 32'd1, 32'd0);
            end else begin
                e    = rd_q.pop_front();
                diff = (rdata >= e.exp) ? rdata - e.exp : e.exp - rdata;
                check(e.tag, (diff <= e.tol) ? e.exp : rdata, e.exp);
            end
        end
        if (we_to_dig) begin
            dig_pulses++;
            if (dig_q.size() == 0) check("dig_unexpected", 32'd1, 32'd0);
            else                   check("dig_wdata", wdata_to_dig, dig_q.pop_front());
        end
    end

    task automatic cyc_store(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        addr = a; wdata = d; we = 1'b1; re = 1'b0;
        if (a == DIG) dig_q.push_back(d);
    endtask

    task automatic cyc_load(input logic [31:0] a, input string tag, input logic [31:0] exp,
                            input logic [31:0] tol);
        rd_exp_t e;
        @(negedge clk);
        addr = a; we = 1'b0; re = 1'b1;
        e.tag = tag; e.exp = exp; e.tol = tol;
        rd_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            we = 1'b0; re = 1'b0;
        end
    endtask

    logic [31:0] hit_addr [7];
    logic        hit_exp  [7];

    initial begin
        rd_exp_t e;
        hit_addr = '{DIG, LED, SW, BTN, 32'hFFFF_F004, 32'h0000_0000, TMR};
`ifdef MMIO_BRIDGE_TIMER_EN
        hit_exp  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
`else
        hit_exp  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
`endif
        repeat (3) @(negedge clk);
        check("rst_we_to_dig", {31'd0, we_to_dig}, 32'd0);
        check("rst_wdata_to_dig", wdata_to_dig, 32'd0);
        check("rst_addr_to_dig", addr_to_dig, 32'd0);
        check("rst_led_out", {8'd0, led_out}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        rst = 1'b0;
        idle(2);

        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            addr = hit_addr[i];
            #1 check($sformatf("hit_%h", hit_addr[i]), {31'd0, hit}, {31'd0, hit_exp[i]});
        end

        cyc_store(DIG, 32'h1234_5678);
        idle(3);
        check("dig_wdata_held", wdata_to_dig, 32'h1234_5678);
        check("dig_addr_held", addr_to_dig, DIG);
        check("dig_pulse_count", dig_pulses, 32'd1);

        cyc_store(LED, 32'hFFAB_CDEF);
        idle(1);
        check("led_out", {8'd0, led_out}, 32'h00AB_CDEF);
        cyc_load(LED, "rd_led", 32'h00AB_CDEF, 32'd0);
        cyc_load(DIG, "rd_dig", 32'h1234_5678, 32'd0);
        idle(2);

        cyc_store(SW, 32'h1111_1111);
        cyc_store(BTN, 32'h2222_2222);
        cyc_store(32'h0000_1000, 32'h3333_3333);
        idle(2);
        check("ignored_led", {8'd0, led_out}, 32'h00AB_CDEF);
        check("ignored_dig", wdata_to_dig, 32'h1234_5678);
        check("ignored_pulses", dig_pulses, 32'd1);

        sw_in = 24'h00F00F;
        idle(3);
        cyc_load(SW, "rd_sw", 32'h0000_F00F, 32'd0);
        idle(2);

        @(negedge clk);
        addr = LED; wdata = 32'h0011_2233; we = 1'b1; re = 1'b1;
        e.tag = "rd_wr_same"; e.exp = 32'h00AB_CDEF; e.tol = 32'd0;
        rd_q.push_back(e);
        idle(2);
        check("led_after_rw", {8'd0, led_out}, 32'h0011_2233);
        cyc_load(LED, "rd_led2", 32'h0011_2233, 32'd0);

        cyc_store(DIG, 32'hAAAA_0001);
        cyc_store(DIG, 32'hBBBB_0002);
        idle(3);
        check("b2b_pulses", dig_pulses, 32'd3);
        check("b2b_last", wdata_to_dig, 32'hBBBB_0002);

        cyc_load(32'hFFFF_F004, "rd_nonhit", 32'd0, 32'd0);
        idle(3);
        check("rd_idle", rdata, 32'd0);

        @(negedge clk);
        btn_in[0] = 1'b1;
        idle(5);
        btn_in[0] = 1'b0;
        idle(25);
        cyc_load(BTN, "btn_glitch", 32'd0, 32'd0);
        idle(2);
        btn_in[0] = 1'b1;
        idle(20);
        cyc_load(BTN, "btn_held", 32'd1, 32'd0);
        idle(2);

`ifdef MMIO_BRIDGE_TIMER_EN
        cyc_store(TMR, 32'd0);
        idle(9);
        cyc_load(TMR, "timer", 32'd10, 32'd1);
        idle(2);
`else
        cyc_store(TMR, 32'd5);
        cyc_load(TMR, "tmr_disabled", 32'd0, 32'd0);
        idle(2);
        check("tmr_no_pulse", dig_pulses, 32'd3);
`endif

        @(negedge clk);
        addr = DIG; wdata = 32'hDEAD_BEEF; we = 1'b1; re = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        we = 1'b0;
        check("midrst_we", {31'd0, we_to_dig}, 32'd0);
        check("midrst_wdata", wdata_to_dig, 32'd0);
        check("midrst_led", {8'd0, led_out}, 32'd0);
        check("midrst_rdata", rdata, 32'd0);
        rst = 1'b0;
        idle(4);
        check("midrst_no_pulse", dig_pulses, 32'd3);
        check("midrst_wdata_after", wdata_to_dig, 32'd0);

        check("rd_q_drained", rd_q.size(), 32'd0);
        check("dig_q_drained", dig_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
